// File: rtl/addsub_accumulator_pkg.sv
// Shared definitions for the add/subtract accumulator: state encoding and default width.
package addsub_accumulator_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/addsub_accumulator_core.sv
// Combinational two's-complement add/subtract with signed-overflow detection.
module addsub_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    always_comb begin
        result = sub ? (a - b) : (a + b);
        // add: same-sign operands flip the sign; sub: differing signs flip it
        if (sub)
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
        else
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/addsub_accumulator.sv
// Sequence accumulator: accepts len operands after start, adding or subtracting each,
// with a sticky signed-overflow flag and a one-cycle done pulse.
module addsub_accumulator
    import addsub_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic             sub,
    output logic [WIDTH-1:0] acc,
    output logic             zero,
    output logic             overflow,
    output logic [3:0]       count,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [3:0]       len_q;
    logic [3:0]       count_inc;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_result;
    logic             core_ovf;

    // The first operand is applied against zero, so LOAD reuses the same adder
    assign core_a    = (state == ST_LOAD) ? '0 : acc;
    assign count_inc = count + 4'd1;
    assign zero      = (acc == '0);

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a      (core_a),
        .b      (operand),
        .sub    (sub),
        .result (core_result),
        .ovf    (core_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            op_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        acc      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        if (len == 4'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            busy     <= 1'b1;
                            op_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD, ST_ACCUM: begin
                    if (op_valid && op_ready) begin
                        acc      <= core_result;
                        count    <= count_inc;
                        overflow <= overflow | core_ovf;
                        if (count_inc == len_q) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            op_ready <= 1'b0;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/addsub_accumulator.md
ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

Interface
REQ-001 Parameter: WIDTH, 8, data width of operands and accumulator.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a new sequence; sampled only in IDLE.
REQ-005 len  input  4  number of operands in the sequence (0-15), captured on accepted start.
REQ-006 op_valid  input  1  operand/sub valid.
REQ-007 op_ready  output  1  block accepts operand this cycle.
REQ-008 operand  input  WIDTH  two's-complement operand.
REQ-009 sub  input  1  1 = subtract operand, 0 = add.
REQ-010 acc  output  WIDTH  registered accumulator.
REQ-011 zero  output  1  acc == 0.
REQ-012 overflow  output  1  sticky signed-overflow flag for current sequence.
REQ-013 count  output  4  operands accepted in current sequence.
REQ-014 busy  output  1  high in LOAD and ACCUM.
REQ-015 done  output  1  one-cycle pulse at sequence end.

Function
REQ-016 FSM states IDLE, LOAD, ACCUM, DONE; encoding from shared package.
REQ-017 IDLE: start=1 and len!=0 -> LOAD, capture len, clear acc, count, overflow.
REQ-018 IDLE: start=1 and len==0 -> DONE, acc cleared to 0, overflow cleared, count=0.
REQ-019 op_ready = 1 in LOAD and ACCUM only; operand accepted when op_valid && op_ready.
REQ-020 LOAD accept: acc <= sub ? (0 - operand) : operand, count <= 1; overflow set if sub and operand == 0x80 (WIDTH=8).
REQ-021 ACCUM accept: acc <= acc + operand (sub=0) or acc - operand (sub=1), modulo 2^WIDTH.
REQ-022 Signed overflow on add: operands same sign, result sign differs; on sub: operand signs differ, result sign differs from acc.
REQ-023 overflow is sticky: once set stays 1 until next accepted start or reset; acc keeps wrapped value (no saturation).
REQ-024 On the accept that makes count == len -> DONE; otherwise remain (LOAD -> ACCUM after first accept).
REQ-025 No accept (op_valid=0) -> state, acc, count hold; gaps of any length allowed.
REQ-026 DONE: done=1 for exactly one cycle, acc/overflow/count hold, next state IDLE.
REQ-027 acc, overflow, count hold their final values in IDLE until next accepted start.
REQ-028 start while busy or in DONE is ignored, no effect.
REQ-029 Latency: result visible on acc one cycle after the accepting edge; done asserts the cycle after the final accept.
REQ-030 zero derived combinationally from registered acc.

Reset
REQ-031 rst=1 forces immediately, independent of clk: state IDLE, acc=0, count=0, overflow=0, done=0, busy=0, op_ready=0; zero=1.
REQ-032 Reset mid-sequence abandons it; no done pulse; operand presented during reset not accepted.

Structure
REQ-033 Shared package holds state typedef/encoding and WIDTH default constant.
REQ-034 One combinational sub-module addsub_core (a, b, sub -> result, signed overflow) instantiated once; FSM and registers in top.

Verification
REQ-035 len=2: (+1,add),(+1,add) -> acc=0x02, zero=0, overflow=0, count=2, done pulse once.
REQ-036 len=2: (100,add),(100,add) -> acc=0xC8, overflow=1; then (0,add) in next sequence len=1 clears overflow -> acc=0x00, zero=1.
REQ-037 len=3: (10,add),(5,sub),(-4 i.e. 0xFC,sub) with op_valid gaps of 2 cycles -> acc=0x09, overflow=0, done exactly once after third accept.
REQ-038 len=2: (-3,add),(4,sub) -> acc=0xF9, overflow=0; start pulsed while busy -> ignored, count stays 2.
REQ-039 len=0 start -> done next cycle, acc=0x00, zero=1, no operand accepted.
REQ-040 rst asserted between clock edges after 1 of 3 operands -> outputs reset immediately, no done, next start runs normally.
